pwm_duty_ramp: RTL

//  Slew-rate-limited duty sequencer feeding the PWM generator's compare input.

---
 rtl/pwm_duty_ramp_pkg.sv | 17 +
 rtl/pwm_tick_gen.sv | 40 ++++
 rtl/pwm_duty_ramp.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_pkg.sv
// rtl/pwm_duty_ramp_pkg.sv - shared definitions for the duty ramp and PWM blocks
// Purpose: FSM state encodings and default clock/precision values shared with
//          the downstream PWM generator.
// Ports:   none (package).
package pwm_duty_ramp_pkg;

    // Encodings are fixed so other blocks can decode the state if needed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ramp_state_t;

    localparam int DEF_CLK_NUM   = 27000000;
    localparam int DEF_PRECISION = 8;

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - periodic tick divider
// Purpose: counts 0..DIV-1 while enabled and flags the last count as a tick.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-low reset
//   clr  in  restart the count at 0 on the next cycle
//   en   in  count enable
//   tick out high for the cycle in which the count equals DIV-1 (while en)
module pwm_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - slew-rate-limited duty sequencer for the PWM compare input
// Purpose: accepts a target duty over valid/ready and steps compare toward it
//          by STEP_SIZE every CLK_NUM/STEP_HZ clocks, clamping the final step.
// Ports:
//   clk           in  system clock
//   rst           in  synchronous active-low reset
//   target        in  requested final duty
//   target_valid  in  target offered
//   breathe       in  continuous triangle breathing (only with PWM_DUTY_RAMP_BREATHE_EN)
//   target_ready  out high only in IDLE and out of reset
//   compare       out current duty to the PWM compare input
//   busy          out ramp in progress
//   done          out one-cycle pulse when compare reaches the accepted target
// Build option: PWM_DUTY_RAMP_BREATHE_EN adds the breathe input.
module pwm_duty_ramp
    import pwm_duty_ramp_pkg::*;
#(
    parameter int CLK_NUM   = DEF_CLK_NUM,
    parameter int PRECISION = DEF_PRECISION,
    parameter int STEP_HZ   = 1000,
    parameter int STEP_SIZE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRECISION-1:0] target,
    input  logic                 target_valid,
`ifdef PWM_DUTY_RAMP_BREATHE_EN
    input  logic                 breathe,
`endif
    output logic                 target_ready,
    output logic [PRECISION-1:0] compare,
    output logic                 busy,
    output logic                 done
);

    localparam int STEP_DIV = CLK_NUM / STEP_HZ;
    localparam logic [PRECISION-1:0] STEP = STEP_SIZE[PRECISION-1:0];

    ramp_state_t          state, state_nxt;
    logic [PRECISION-1:0] compare_nxt;
    logic [PRECISION-1:0] tgt, tgt_nxt;
    logic                 done_nxt;
    logic                 accept;
    logic [PRECISION-1:0] acc_tgt;
    logic                 tick;

    pwm_tick_gen #(
        .DIV (STEP_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (busy),
        .tick (tick)
    );

    assign busy         = (state != ST_IDLE);
    assign target_ready = (state == ST_IDLE) && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            compare <= '0;
            tgt     <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            compare <= compare_nxt;
            tgt     <= tgt_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        compare_nxt = compare;
        tgt_nxt     = tgt;
        done_nxt    = 1'b0;
        accept      = 1'b0;
        acc_tgt     = target;

        // An external offer always wins; breathing only self-accepts when idle
        // and nobody upstream is asking for a specific duty.
        if (target_ready) begin
            if (target_valid) begin
                accept  = 1'b1;
                acc_tgt = target;
            end
`ifdef PWM_DUTY_RAMP_BREATHE_EN
            else if (breathe) begin
                accept  = 1'b1;
                acc_tgt = (compare == '0) ? '1 : '0;
            end
`endif
        end

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tgt_nxt = acc_tgt;
                    if (acc_tgt > compare) begin
                        state_nxt = ST_UP;
                    end else if (acc_tgt < compare) begin
                        state_nxt = ST_DOWN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            // Step decisions use the remaining distance so compare never wraps.
            ST_UP: begin
                if (tick) begin
                    if ((tgt - compare) <= STEP) begin
                        compare_nxt = tgt;
                        state_nxt   = ST_IDLE;
                        done_nxt    = 1'b1;
                    end else begin
                        compare_nxt = compare + STEP;
                    end
                end
            end
            ST_DOWN: begin
                if (tick) begin
                    if ((compare - tgt) <= STEP) begin
                        compare_nxt = tgt;
                        state_nxt   = ST_IDLE;
                        done_nxt    = 1'b1;
                    end else begin
                        compare_nxt = compare - STEP;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
